// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract datapath.
// Opcode encodings match the `sub` select input of pipelined_add_sub.
package adder_pkg;

    // Operation select values for the `sub` input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits of carry chain handled by each pipeline stage.
    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple slice with carry in/out; one per pipeline stage.
module add_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor with carry, overflow and zero flags.
// The carry chain is cut into STAGES slices; each stage register carries the
// operands still to be consumed and the result bits already produced.
// All stages advance together unless the output beat is stalled.
// Optional build macro PIPELINED_ADD_SUB_SAT_EN: saturate the result to the
// signed extreme on overflow (carry/overflow still describe the wrapped op).
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SLICE_W = slice_w(WIDTH, STAGES);
    localparam int unsigned LAST    = STAGES - 1;
    localparam int unsigned MSB     = WIDTH - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    // Per-stage state; index k holds the beat that has finished slice k.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] bp_q, bp_d;
    logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
    logic [STAGES-1:0][WIDTH-1:0] res_raw;

    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] final_res;
    logic             stall;
    logic             unused_bits;

    // A held output beat freezes the whole pipe, so acceptance is blocked too.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]   a_in;
        logic [WIDTH-1:0]   bp_in;
        logic [WIDTH-1:0]   res_in;
        logic               c_in;
        logic [SLICE_W-1:0] sum;
        logic [WIDTH-1:0]   raw;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1: invert B here and inject the +1 as carry-in.
            assign valid_d[k] = in_valid;
            assign a_in       = a;
            assign bp_in      = (sub == OP_SUB) ? ~b : b;
            assign res_in     = '0;
            assign c_in       = (sub == OP_SUB);
        end else begin : g_body
            assign valid_d[k] = valid_q[k-1];
            assign a_in       = a_q[k-1];
            assign bp_in      = bp_q[k-1];
            assign res_in     = res_q[k-1];
            assign c_in       = carry_q[k-1];
        end

        add_slice #(
            .W (SLICE_W)
        ) u_slice (
            .a    (a_in[k*SLICE_W +: SLICE_W]),
            .b    (bp_in[k*SLICE_W +: SLICE_W]),
            .cin  (c_in),
            .sum  (sum),
            .cout (carry_d[k])
        );

        // Merge this stage's slice into the partial result carried from upstream.
        always_comb begin
            raw                        = res_in;
            raw[k*SLICE_W +: SLICE_W] = sum;
        end

        assign a_d[k]     = a_in;
        assign bp_d[k]    = bp_in;
        assign res_raw[k] = raw;

        if (k == LAST) begin : g_tail
            assign res_d[k] = final_res;
        end else begin : g_mid
            assign res_d[k] = raw;
        end
    end

    // Signed overflow: both addends share a sign that the wrapped result lacks.
    assign overflow_d = (a_d[LAST][MSB] == bp_d[LAST][MSB]) &&
                        (res_raw[LAST][MSB] != a_d[LAST][MSB]);

`ifdef PIPELINED_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(1) << MSB;
    localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;

    // Clamp toward the sign of A, which is also the sign of the true result.
    assign final_res = overflow_d ? (a_d[LAST][MSB] ? SAT_MIN : SAT_MAX) : res_raw[LAST];
`else
    assign final_res = res_raw[LAST];
`endif

    assign zero_d = ~|final_res;

    // Stage registers: cleared by reset, otherwise advance in lock-step unless stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            carry_q    <= '0;
            a_q        <= '0;
            bp_q       <= '0;
            res_q      <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (!stall) begin
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            bp_q       <= bp_d;
            res_q      <= res_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign result    = res_q[LAST];
    assign carry     = carry_q[LAST];
    assign overflow  = overflow_q;
    assign zero      = zero_q;

    // Already-consumed operand bits ride along but are never read again.
    assign unused_bits = ^{a_q, bp_q};

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised successor to the ALU's 8-bit combinational adder.
- Splits the carry chain across STAGES registered slices so wide add/subtract closes timing at higher clock rates.
- Produces carry, signed-overflow and zero flags.
- Streaming valid/ready handshake with full back-pressure; sits between the register-file read stage and writeback in multi-cycle datapath variants.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages, which equals latency in cycles; 1..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  sum/difference.
- carry  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; all state is cleared on the clk edge where reset=1.
- Reset values: all stage valid bits = 0, so out_valid = 0. Also in_ready = 1, result = 0, carry = 0, overflow = 0, zero = 0.
- SLICE_W = WIDTH/STAGES. Stage k adds bits [k*SLICE_W +: SLICE_W] of A and B' with the carry registered from stage k-1.
  - B' = sub ? ~b : b; stage 0 carry-in = sub.
  - Operand bits not yet consumed travel alongside in the stage registers; result bits already computed also travel alongside.
- Stall rule: stall = out_valid & ~out_ready.
  - When stall=1, every stage register holds.
  - When stall=0, all stages advance together (a bubble moves as valid=0).
- in_ready = ~stall, combinational from out_valid/out_ready. A beat is accepted when in_valid & in_ready.
- Latency: with no stalls, a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (STAGES=1 is registered output, 1 cycle). Throughput is 1 beat/cycle.
- Flags are computed in the final stage:
  - carry = carry out of bit WIDTH-1.
  - overflow = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]).
  - zero = ~|result.
- Outputs hold stable while out_valid & ~out_ready; the consumer may see the same beat for many cycles.
- in_valid=0 with stall=0 inserts a bubble; the valid bit propagates as 0.
- A simultaneous accept and output handshake in the same cycle is legal; there is no loss and no duplication.
- reset mid-operation: all in-flight beats are discarded; out_valid=0 the cycle after; no partial result is emitted.
- Wrap-around: arithmetic is modulo 2^WIDTH; flags report the wrap.

Optional Feature:
- Macro: PIPELINED_ADD_SUB_SAT_EN.
- Defined: when overflow=1, result saturates to the signed extreme.
  - A[MSB]=0 gives 0111..1.
  - A[MSB]=1 gives 1000..0.
  - carry and overflow still report the unsaturated operation; zero reflects the saturated result.
- Undefined: wrapping result only; no saturation logic is synthesised.

Decomposition:
- Package adder_pkg: localparam helper SLICE_W(WIDTH,STAGES); constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module add_slice: combinational SLICE_W-bit adder with carry in/out. It is instantiated STAGES times inside a generate loop, with the stage registers in the parent.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- add 0xFF+0x01, out_ready=1 -> after 2 cycles result=0x00, carry=1, zero=1, overflow=0.
- add 0x7F+0x01 -> result=0x80, overflow=1, carry=0; with PIPELINED_ADD_SUB_SAT_EN -> result=0x7F, overflow=1.
- sub 0x05-0x07 -> result=0xFE, carry=0, overflow=0; sub 0x80-0x01 -> result=0x7F, overflow=1; SAT_EN -> result=0x80.
- Stream 4 beats back-to-back (0x10+0x01, 0x20+0x02, 0x30+0x03, 0x40+0x04) with out_ready=0 for 3 cycles mid-stream:
  - in_ready drops while stalled; outputs hold.
  - Results 0x11, 0x22, 0x33, 0x44 emerge in order with no loss or duplicates.
- Assert reset for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, all outputs 0, no stale beat later, in_ready=1.
- WIDTH=32, STAGES=4: random 10k beats with random in_valid/out_ready -> every result/flag matches the {a±b} reference model, in order.
